// File: rtl/mult_pkg.sv
// Shared definitions for the HI/LO multiply sequencer: FSM encoding and
// default sizing tied to the fast multiplier's adder-tree depth.
package mult_pkg;

  localparam int unsigned DEF_WIDTH    = 32;
  localparam int unsigned DEF_MULT_LAT = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/mult_sign_fix.sv
// Combinational conditional two's-complement negate; used for operand
// magnitudes and for restoring the sign of the product.
module mult_sign_fix #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] a,
  input  logic         neg,
  output logic [W-1:0] y
);

  always_comb begin
    y = neg ? (~a + W'(1)) : a;
  end

endmodule

// File: rtl/hilo_mult_ctrl.sv
// MULT/MULTU sequencer around the pipelined unsigned multiplier; owns the
// architectural HI/LO registers and the MFHI/MFLO stall indication.
module hilo_mult_ctrl
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned MULT_LAT = DEF_MULT_LAT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  input  logic               mthi,
  input  logic               mtlo,
  input  logic [WIDTH-1:0]   wdata,
  output logic [WIDTH-1:0]   mult_a,
  output logic [WIDTH-1:0]   mult_b,
  input  logic [2*WIDTH-1:0] mult_p,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo
);

  localparam int unsigned CW = $clog2(MULT_LAT + 1);

  state_t             state, next_state;
  logic [CW-1:0]      cnt;
  logic               neg;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   mag_a, mag_b;

  mult_sign_fix #(.W(WIDTH)) u_fix_a (
    .a   (op_a),
    .neg (is_signed & op_a[WIDTH-1]),
    .y   (mag_a)
  );

  mult_sign_fix #(.W(WIDTH)) u_fix_b (
    .a   (op_b),
    .neg (is_signed & op_b[WIDTH-1]),
    .y   (mag_b)
  );

  mult_sign_fix #(.W(2*WIDTH)) u_fix_p (
    .a   (prod),
    .neg (neg),
    .y   (prod_fix)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (start) next_state = WAIT;
      WAIT:    if (cnt == CW'(1)) next_state = FIX;
      FIX:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  // A start in IDLE takes priority over MTHI/MTLO in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mult_a <= '0;
      mult_b <= '0;
      neg    <= 1'b0;
      cnt    <= '0;
      prod   <= '0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            mult_a <= mag_a;
            mult_b <= mag_b;
            neg    <= is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
            cnt    <= CW'(MULT_LAT);
          end else begin
            if (mthi) hi <= wdata;
            if (mtlo) lo <= wdata;
          end
        end
        WAIT: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) prod <= mult_p;
        end
        FIX: begin
          {hi, lo} <= prod_fix;
          done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/hilo_mult_ctrl.md
Name: hilo_mult_ctrl

Overview:
Sequencer for the MIPS MULT/MULTU path. It sits directly upstream and downstream of the pipelined unsigned fast multiplier. It converts signed operands to magnitudes and issues them to the multiplier. After the fixed pipeline latency it captures the 64-bit product, applies the sign correction and writes the architectural HI/LO registers. It also handles MTHI/MTLO writes and asserts busy so the core stalls MFHI/MFLO while a multiply is in flight.

Parameters:
WIDTH, 32, operand width; HI/LO are WIDTH each, product is 2*WIDTH.
MULT_LAT, 5, clock edges from mult_a/mult_b becoming valid to mult_p being valid. This is one per registered adder level of the multiplier tree. Legal range is 1 or more.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  issue multiply using op_a/op_b; sampled only in IDLE
is_signed  input  1  1 = MULT (signed), 0 = MULTU
op_a  input  WIDTH  multiplicand (rs)
op_b  input  WIDTH  multiplier (rt)
mthi  input  1  write wdata to HI
mtlo  input  1  write wdata to LO
wdata  input  WIDTH  MTHI/MTLO data
mult_a  output  WIDTH  registered magnitude of op_a to multiplier
mult_b  output  WIDTH  registered magnitude of op_b to multiplier
mult_p  input  2*WIDTH  unsigned product from multiplier
busy  output  1  multiply in flight; core stalls MFHI/MFLO/MULT
done  output  1  one-cycle pulse, HI/LO updated by a multiply
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset (async, rst=1): state=IDLE; hi, lo, mult_a, mult_b, product register, neg flag and counter = 0; busy=0; done=0. Reset mid-operation aborts the multiply; no HI/LO write follows.
- States: IDLE, WAIT, FIX. busy=1 in WAIT and FIX. busy is decoded from the registered state.
- IDLE, start=1 at edge E0:
  - mult_a <= |op_a| and mult_b <= |op_b|. The absolute value is taken only if is_signed; otherwise operands pass raw.
  - neg <= is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]).
  - cnt <= MULT_LAT; state -> WAIT.
- Magnitude of the most negative value (0x80000000) is 0x80000000 as unsigned; no overflow.
- WAIT: cnt decrements each edge. At the edge where cnt==1, prod <= mult_p and state -> FIX. This is edge E0+MULT_LAT.
- mult_a and mult_b hold stable throughout WAIT.
- FIX, next edge (E0+MULT_LAT+1):
  - {hi,lo} <= neg ? (~prod + 1) : prod, using 2*WIDTH two's complement.
  - done <= 1 for exactly one cycle.
  - state -> IDLE.
- busy is high for MULT_LAT+1 cycles after E0. New HI/LO values are visible in the cycle done=1.
- start while busy: ignored; no queueing.
- mthi/mtlo in IDLE with start=0: hi/lo <= wdata at the next edge. Both may assert together, writing the same wdata to both.
- mthi/mtlo while busy, or in the same cycle as an accepted start: ignored. The multiply result owns HI/LO.
- done is low in all other cycles.
- op_a, op_b and is_signed need only be valid in the start cycle.

Decomposition:
- Shared package mult_pkg holds:
  - the state encoding (IDLE=2'd0, WAIT=2'd1, FIX=2'd2);
  - WIDTH default 32;
  - MULT_LAT default 5, tied to the multiplier's adder-level count.
- One natural sub-module, mult_sign_fix: combinational conditional two's-complement negate, parameterised by width. It is instantiated twice for the operands (WIDTH) and once for the product (2*WIDTH).
- The bench models the multiplier as MULT_LAT stages of registers carrying mult_a*mult_b.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> busy high 6 cycles; done pulse; hi=0xFFFFFFFE, lo=0x00000001.
- MULT -3 (0xFFFFFFFD) x 5 -> mult_a=3, mult_b=5, neg=1; hi=0xFFFFFFFF, lo=0xFFFFFFF1. MULT 0xFFFFFFFF x 0xFFFFFFFF -> hi=0, lo=1.
- MULT 0x80000000 x 0x80000000 -> mult_a=mult_b=0x80000000; hi=0x40000000, lo=0x00000000. MULT 0x80000000 x 1 -> hi=0xFFFFFFFF, lo=0x80000000.
- Second start, plus mthi with wdata=0x1234, issued 2 cycles after an accepted start (3 x 4) -> both ignored; hi=0, lo=12; exactly one done pulse.
- IDLE: mthi and mtlo together with wdata=0xDEADBEEF -> hi=lo=0xDEADBEEF next cycle; done stays 0.
- rst pulsed in WAIT -> immediately hi=lo=0, busy=0; no done afterwards. A following MULTU 7 x 6 -> lo=42, hi=0.
